// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - colours, geometry defaults and draw-state encoding shared by renderer and game logic
package dino_pkg;

    localparam logic [2:0] BG   = 3'b011;
    localparam logic [2:0] DINO = 3'b010;
    localparam logic [2:0] OBS1 = 3'b100;
    localparam logic [2:0] OBS2 = 3'b101;
    localparam logic [2:0] GRND = 3'b110;

    localparam int DINO_LEFT_DEF  = 15;
    localparam int DINO_W_DEF     = 10;
    localparam int DINO_H_DEF     = 12;
    localparam int OBS_W_DEF      = 12;
    localparam int GROUND_TOP_DEF = 105;
    localparam int X_MAX_DEF      = 159;
    localparam int Y_MAX_DEF      = 119;

    typedef enum logic [3:0] {
        IDLE, FILL_SKY, FILL_GND,
        ERASE_OBS2, ERASE_OBS1, ERASE_DINO,
        DRAW_OBS2, DRAW_OBS1, DRAW_DINO,
        DONE
    } draw_state_e;

    typedef struct packed {
        logic [7:0] dino_y;
        logic [7:0] o1_x;
        logic [7:0] o1_h;
        logic [7:0] o2_x;
        logic [7:0] o2_h;
    } pos_t;

    // Obstacles grow upward from the ground; taller ones are cut at the top of the sky.
    function automatic logic [7:0] clamp_h(input logic [7:0] h, input int top);
        return (h > 8'(top)) ? 8'(top) : h;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - row-major rectangle address generator, one pixel per cycle, no idle cycle between rectangles
module rect_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] x0,
    input  logic [8:0] y0,
    input  logic [8:0] w,
    input  logic [8:0] h,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       valid,
    output logic       last
);

    logic [8:0] cx_q, cy_q;

    // start holds the counters at the origin so the first address is ready on the first cycle of a rectangle
    assign valid = !start && (w != 9'd0) && (h != 9'd0);
    assign last  = valid && (cx_q == w - 9'd1) && (cy_q == h - 9'd1);
    assign x     = x0 + cx_q;
    assign y     = y0 + cy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (!valid || last) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (cx_q == w - 9'd1) begin
            cx_q <= '0;
            cy_q <= cy_q + 9'd1;
        end else begin
            cx_q <= cx_q + 9'd1;
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// rtl/sprite_draw_sequencer.sv - per-frame erase/redraw of dino and two obstacles into a vga_adapter
// Build option DRAW_SKIP_UNCHANGED_EN: objects that did not move are neither erased nor redrawn.
module sprite_draw_sequencer
    import dino_pkg::*;
#(
    parameter int DINO_LEFT  = DINO_LEFT_DEF,
    parameter int DINO_W     = DINO_W_DEF,
    parameter int DINO_H     = DINO_H_DEF,
    parameter int OBS_W      = OBS_W_DEF,
    parameter int GROUND_TOP = GROUND_TOP_DEF,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MAX      = Y_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] dinoY,
    input  logic [7:0] obs1X,
    input  logic [7:0] obs1H,
    input  logic [7:0] obs2X,
    input  logic [7:0] obs2H,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    draw_state_e state_q, state_d;
    pos_t        pos_in, snap_q, prev_q, cur;
    logic        prev_valid_q, overrun_q;
    logic [7:0]  h1_cur, h2_cur, h1_prev, h2_prev;
    logic        same_dino, same_o1, same_o2;
    logic [5:0]  act;
    logic [8:0]  rx0, ry0, rw, rh, sx, sy;
    logic [2:0]  rcol;
    logic        scan_start, scan_valid, scan_last;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  color_q;
    logic        plot_q;

    assign pos_in = {dinoY, obs1X, obs1H, obs2X, obs2H};
    // In IDLE the sequencer must decide its first state from the values being snapshotted this cycle.
    assign cur    = (state_q == IDLE) ? pos_in : snap_q;

    assign h1_cur  = clamp_h(cur.o1_h, GROUND_TOP);
    assign h2_cur  = clamp_h(cur.o2_h, GROUND_TOP);
    assign h1_prev = clamp_h(prev_q.o1_h, GROUND_TOP);
    assign h2_prev = clamp_h(prev_q.o2_h, GROUND_TOP);

`ifdef DRAW_SKIP_UNCHANGED_EN
    assign same_dino = prev_valid_q && (cur.dino_y == prev_q.dino_y);
    assign same_o1   = prev_valid_q && (cur.o1_x == prev_q.o1_x) && (cur.o1_h == prev_q.o1_h);
    assign same_o2   = prev_valid_q && (cur.o2_x == prev_q.o2_x) && (cur.o2_h == prev_q.o2_h);
`else
    assign same_dino = 1'b0;
    assign same_o1   = 1'b0;
    assign same_o2   = 1'b0;
`endif

    // One bit per ERASE/DRAW state, in state order; a clear bit means that state takes zero cycles.
    assign act[0] = prev_valid_q && (h2_prev != 8'd0) && !same_o2;
    assign act[1] = prev_valid_q && (h1_prev != 8'd0) && !same_o1;
    assign act[2] = prev_valid_q && !same_dino;
    assign act[3] = (h2_cur != 8'd0) && !same_o2;
    assign act[4] = (h1_cur != 8'd0) && !same_o1;
    assign act[5] = !same_dino;

    function automatic draw_state_e next_rect(input logic [5:0] mask, input int from);
        draw_state_e n = DONE;
        for (int k = int'(DRAW_DINO); k >= int'(ERASE_OBS2); k--) begin
            if (k > from && mask[k - int'(ERASE_OBS2)]) n = draw_state_e'(4'(k));
        end
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        scan_start = 1'b0;
        rx0        = '0;
        ry0        = '0;
        rw         = '0;
        rh         = '0;
        rcol       = BG;
        case (state_q)
            IDLE: begin
                scan_start = 1'b1;
                if (frame_tick) state_d = prev_valid_q ? next_rect(act, int'(FILL_GND)) : FILL_SKY;
            end
            FILL_SKY: begin
                rw = 9'(X_MAX + 1);
                rh = 9'(GROUND_TOP);
            end
            FILL_GND: begin
                ry0  = 9'(GROUND_TOP);
                rw   = 9'(X_MAX + 1);
                rh   = 9'(Y_MAX - GROUND_TOP + 1);
                rcol = GRND;
            end
            ERASE_OBS2, DRAW_OBS2: begin
                rx0  = (state_q == DRAW_OBS2) ? {1'b0, cur.o2_x} : {1'b0, prev_q.o2_x};
                rh   = (state_q == DRAW_OBS2) ? {1'b0, h2_cur} : {1'b0, h2_prev};
                ry0  = 9'(GROUND_TOP) - rh;
                rw   = 9'(OBS_W);
                rcol = (state_q == DRAW_OBS2) ? OBS2 : BG;
            end
            ERASE_OBS1, DRAW_OBS1: begin
                rx0  = (state_q == DRAW_OBS1) ? {1'b0, cur.o1_x} : {1'b0, prev_q.o1_x};
                rh   = (state_q == DRAW_OBS1) ? {1'b0, h1_cur} : {1'b0, h1_prev};
                ry0  = 9'(GROUND_TOP) - rh;
                rw   = 9'(OBS_W);
                rcol = (state_q == DRAW_OBS1) ? OBS1 : BG;
            end
            ERASE_DINO, DRAW_DINO: begin
                rx0  = 9'(DINO_LEFT);
                ry0  = (state_q == DRAW_DINO) ? {1'b0, cur.dino_y} : {1'b0, prev_q.dino_y};
                rw   = 9'(DINO_W);
                rh   = 9'(DINO_H);
                rcol = (state_q == DRAW_DINO) ? DINO : BG;
            end
            DONE: begin
                scan_start = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                scan_start = 1'b1;
                state_d    = IDLE;
            end
        endcase
        if (scan_last) state_d = (state_q == FILL_SKY) ? FILL_GND : next_rect(act, int'(state_q));
    end

    rect_scanner u_scan (
        .clk   (clk),
        .rst   (reset),
        .start (scan_start),
        .x0    (rx0),
        .y0    (ry0),
        .w     (rw),
        .h     (rh),
        .x     (sx),
        .y     (sy),
        .valid (scan_valid),
        .last  (scan_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= BG;
            plot_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && frame_tick) snap_q <= pos_in;
            if (state_q != IDLE && frame_tick) overrun_q <= 1'b1;
            if (state_q == DONE) begin
                prev_q       <= snap_q;
                prev_valid_q <= 1'b1;
            end
            // Off-screen pixels still take their cycle but never reach the frame buffer.
            plot_q <= scan_valid && (sx <= 9'(X_MAX)) && (sy <= 9'(Y_MAX));
            if (scan_valid) begin
                x_q     <= sx[7:0];
                y_q     <= sy[6:0];
                color_q <= rcol;
            end
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign color   = color_q;
    assign plot    = plot_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb/tb_sprite_draw_sequencer.sv - self-checking bench for sprite_draw_sequencer against a pixel-list model
module tb_sprite_draw_sequencer;

`ifdef DRAW_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] dy;
        logic [7:0] o1x;
        logic [7:0] o1h;
        logic [7:0] o2x;
        logic [7:0] o2h;
    } pos_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        pos_t p;
        int   retick;
        int   exp_busy;
        int   exp_plots;
        int   exp_ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, frame_tick;
    logic [7:0] dinoY, obs1X, obs1H, obs2X, obs2H;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot, busy, done, overrun;

    always #5 clk = ~clk;

    sprite_draw_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .dinoY(dinoY), .obs1X(obs1X), .obs1H(obs1H), .obs2X(obs2X), .obs2H(obs2H),
        .x(x), .y(y), .color(color), .plot(plot),
        .busy(busy), .done(done), .overrun(overrun)
    );

    int   n_vec = 0;
    int   n_err = 0;
    pix_t exp_q[$];
    pix_t act_q[$];
    int   exp_cycles;
    bit   m_valid;
    pos_t m_prev;
    int   g_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic add_rect(input int x0, input int y0, input int w, input int h, input int c);
        for (int r = 0; r < h; r++)
            for (int col = 0; col < w; col++) begin
                exp_cycles++;
                if (x0 + col <= 159 && y0 + r <= 119) exp_q.push_back('{x0 + col, y0 + r, c});
            end
    endtask

    function automatic int clampv(input int h);
        return (h > 105) ? 105 : h;
    endfunction

    // obj 0 = obs2, 1 = obs1, 2 = dino
    task automatic add_obj(input int obj, input pos_t v, input int c);
        if (obj == 0)      add_rect(int'(v.o2x), 105 - clampv(int'(v.o2h)), 12, clampv(int'(v.o2h)), c);
        else if (obj == 1) add_rect(int'(v.o1x), 105 - clampv(int'(v.o1h)), 12, clampv(int'(v.o1h)), c);
        else               add_rect(15, int'(v.dy), 10, 12, c);
    endtask

    function automatic bit same_obj(input int obj, input pos_t a, input pos_t b);
        if (obj == 0) return (a.o2x == b.o2x) && (a.o2h == b.o2h);
        if (obj == 1) return (a.o1x == b.o1x) && (a.o1h == b.o1h);
        return a.dy == b.dy;
    endfunction

    task automatic model_pass(input pos_t cur);
        int draw_col[3];
        draw_col = '{5, 4, 2};
        exp_q.delete();
        exp_cycles = 0;
        if (!m_valid) begin
            add_rect(0, 0, 160, 105, 3);
            add_rect(0, 105, 160, 15, 6);
        end else begin
            for (int o = 0; o < 3; o++)
                if (!(SKIP && same_obj(o, cur, m_prev))) add_obj(o, m_prev, 3);
        end
        for (int o = 0; o < 3; o++)
            if (!(SKIP && m_valid && same_obj(o, cur, m_prev))) add_obj(o, cur, draw_col[o]);
        m_prev  = cur;
        m_valid = 1'b1;
    endtask

    task automatic run_pass(input pos_t p, input int retick_at);
        int done_n, done_at, t, ndiff;
        {dinoY, obs1X, obs1H, obs2X, obs2H} = p;
        frame_tick = 1'b1;
        model_pass(p);
        @(negedge clk);
        frame_tick = 1'b0;
        act_q.delete();
        g_busy = 0; done_n = 0; done_at = -1; t = 0;
        while (busy && t < exp_cycles + 50) begin
            if (plot) act_q.push_back('{int'(x), int'(y), int'(color)});
            if (done) begin done_n++; done_at = g_busy; end
            g_busy++;
            {dinoY, obs1X, obs1H, obs2X} = $urandom;
            obs2H = 8'($urandom);
            frame_tick = (g_busy == retick_at);
            @(negedge clk);
            t++;
        end
        frame_tick = 1'b0;
        check("busy_len", g_busy, exp_cycles + 1);
        check("done_count", done_n, 1);
        check("done_last", done_at, g_busy - 1);
        check("stream_len", act_q.size(), exp_q.size());
        ndiff = 0;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            if (exp_q[i].x != act_q[i].x || exp_q[i].y != act_q[i].y || exp_q[i].c != act_q[i].c) ndiff++;
        check("stream_diff", ndiff, 0);
        check("idle_plot", plot, 0);
        check("idle_done", done, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_color"}, color, 3);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        pos_t p;
        int   cnt, miny, found_e, found_d;
        bit   hit;

        tbl[0] = '{{8'd93, 8'd120, 8'd7, 8'd254, 8'd14}, -1, 19573, 19404, 0};
        tbl[1] = '{{8'd93, 8'd119, 8'd7, 8'd254, 8'd14}, 50, SKIP ? 169 : 745, SKIP ? 168 : 408, 1};
        tbl[2] = '{{8'd93, 8'd119, 8'd7, 8'd254, 8'd14}, -1, SKIP ? 1 : 745, SKIP ? 0 : 408, 1};
        tbl[3] = '{{8'd93, 8'd60, 8'd0, 8'd30, 8'd200}, -1, SKIP ? 1513 : 1753, SKIP ? 1344 : 1584, 1};

        reset = 1'b1; frame_tick = 1'b0;
        {dinoY, obs1X, obs1H, obs2X, obs2H} = '0;
        m_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("tick_in_reset_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_pass(tbl[i].p, tbl[i].retick);
            check($sformatf("tbl%0d_busy", i), g_busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_plots", i), act_q.size(), tbl[i].exp_plots);
            check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].exp_ovr);
            if (i == 1) begin
                found_e = 0; found_d = 0;
                foreach (act_q[k]) begin
                    if (act_q[k].x == 131 && act_q[k].y == 98 && act_q[k].c == 3) found_e = 1;
                    if (act_q[k].x == 119 && act_q[k].y == 98 && act_q[k].c == 4) found_d = 1;
                end
                check("erase_131_98", found_e, 1);
                check("draw_119_98", found_d, 1);
            end
            if (i == 3) begin
                cnt = 0; miny = 999;
                foreach (act_q[k]) if (act_q[k].c == 5) begin
                    cnt++;
                    if (act_q[k].y < miny) miny = act_q[k].y;
                end
                check("obs2_clamped_plots", cnt, 1260);
                check("obs2_top_row", miny, 0);
                cnt = 0;
                foreach (act_q[k]) if (act_q[k].c == 4) cnt++;
                check("obs1_zero_h", cnt, 0);
            end
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 4; r++) begin
            p = m_prev;
            if ($urandom_range(0, 1)) p.dy = 8'($urandom_range(0, 130));
            if ($urandom_range(0, 1)) begin p.o1x = 8'($urandom); p.o1h = 8'($urandom); end
            if ($urandom_range(0, 1)) begin p.o2x = 8'($urandom); p.o2h = 8'($urandom); end
            run_pass(p, -1);
            repeat (2) @(negedge clk);
        end

        p = m_prev;
        p.o1x = 8'd40; p.o1h = 8'd20; p.dy = 8'd50;
        {dinoY, obs1X, obs1H, obs2X, obs2H} = p;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 6000 && !hit; t++) begin
            if (plot && color == 3'b100) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_draw_obs1", hit, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        p.o1x = 8'd70;
        run_pass(p, -1);
        cnt = 0;
        foreach (act_q[k]) if (act_q[k].c == 3 || act_q[k].c == 6) cnt++;
        check("refill_plots", cnt, 19200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
